uart_rx_oversample: RTL
=======================

Name: uart_rx_oversample

Overview:
Standalone 8N1/8E1/8O1 UART receiver with its own 16x oversampling tick. Takes 3-sample majority vote per bit, rejects glitches on the start bit, and flags framing, parity, overrun and break conditions. Delivers bytes through a one-entry valid/ready holding register. It is the receiving end for uart_transmitter when the far side is an external device, not the on-chip loopback.

Parameters:
CLK_FREQ, 100_000_000, system clock in Hz
BAUD_RATE, 115200, line rate in bit/s
OVERSAMPLE, 16, samples per bit; must be >= 8
PARITY_EN, 0, 1 = a parity bit follows the data bits
PARITY_ODD, 0, 1 = odd parity, 0 = even parity; ignored when PARITY_EN=0

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
rx_line  input  1  asynchronous serial input, idle high
rx_valid  output  1  holding register contains a byte
rx_ready  input  1  consumer accepts the byte when rx_valid && rx_ready
rx_data  output  8  received byte, LSB received first
frame_err  output  1  stop bit sampled low; qualified by rx_valid
parity_err  output  1  parity mismatch; qualified by rx_valid; 0 when PARITY_EN=0
overrun_err  output  1  sticky: a completed byte was dropped
err_clr  input  1  clears overrun_err
busy  output  1  FSM is not in IDLE

Behaviour:
- Reset (rst=0, asynchronous): synchronizer flops = 1, FSM = IDLE, rx_valid=0, rx_data=0x00, frame_err=0, parity_err=0, overrun_err=0, busy=0.
- rx_line passes through a 2-FF synchronizer; all decisions use the second flop (rxs). This adds 2 clk of input latency.
- Tick: DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), truncated (54 at defaults). One-clk tick pulse every DIV clocks. The divider reloads on start detection so sampling is phase-aligned to the falling edge.
- Sample counter: sc, 0..OVERSAMPLE-1, advances on each tick. rxs is captured at sc = M-1, M, M+1 (M = OVERSAMPLE/2). The bit value is the majority of the three captures, decided at sc = M+1.
- FSM states: IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
- IDLE: when rxs==0, clear sc and divider and go to START.
- START: on the vote, a result of 1 is a glitch; return to IDLE and emit nothing. A result of 0 goes to DATA at the sc=OVERSAMPLE-1 wrap.
- DATA: 8 bits, shifted in LSB first, bit index 0..7. After bit 7 wraps, go to PARITY if PARITY_EN, else STOP.
- PARITY: capture the voted bit. Error when XOR(data, bit) != PARITY_ODD.
- STOP: the frame completes at the stop-bit vote (sc = M+1), not at end of bit, so back-to-back frames are tolerated.
  - Vote 1: go to IDLE.
  - Vote 0: frame_err. If data==0x00 also, this is a break; go to BRK_WAIT.
- BRK_WAIT: stay until rxs==1, then go to IDLE. No new start detection happens while in this state.
- Completion, in the same cycle as the stop vote: rx_data, frame_err and parity_err load together and rx_valid rises on the next clk edge. Total latency from stop-bit falling/mid edge is at most 2 sync + 1 clk.
- Handshake:
  - rx_valid stays high until rx_valid && rx_ready. rx_data and the error flags are stable while rx_valid=1.
  - Accept with no completion in the same cycle: rx_valid drops next clk.
- Simultaneous completion and accept: the new byte loads and rx_valid stays 1. No overrun.
- Completion with rx_valid=1 and no accept: the new byte is discarded, the old byte is retained, and overrun_err is set.
- overrun_err: set and err_clr in the same cycle means set wins. Otherwise err_clr clears it next clk.
- Reset mid-frame: the partial byte is abandoned and the block returns to the reset state immediately.

Decomposition:
- uart_defs.vh, shared with the existing UART blocks:
  - FSM state encodings (3-bit).
  - Default CLK_FREQ and BAUD_RATE.
  - Majority-vote helper macro.
- One sub-module, uart_os_tick: the divider with synchronous reload input, producing a one-clk tick. It is reusable by a future oversampled transmitter.

Test Plan (defaults: DIV=54, 1 bit = 864 clk):
- Send 0xA5 as 8N1 with rx_ready=1 -> one rx_valid pulse, rx_data=0xA5, frame_err=0, parity_err=0.
- Low glitch of 300 clk on idle line -> START vote=1, no rx_valid, busy returns to 0 within 1 bit time.
- Send 0x3C then 0x81 with rx_ready=0, then raise rx_ready -> rx_data=0x3C retained, overrun_err=1; err_clr clears it next clk.
- Send 0x55 with stop bit driven low -> rx_valid with frame_err=1, rx_data=0x55. Hold line low 10 bit times -> single byte 0x00 with frame_err=1, and no further bytes until the line is high.
- PARITY_EN=1, PARITY_ODD=0: send 0x07 with parity 1 -> parity_err=0. Send it with parity 0 -> parity_err=1.
- Single-clk spikes inverted at sc=M on every data bit of 0xF0, plus a back-to-back stream of 0x01, 0x02, 0x03 -> all bytes correct, and rst pulsed mid-byte gives no output until the next full frame.

Source files
------------

// File: rtl/uart_rx_oversample_pkg.sv
// Shared definitions for the oversampled UART receiver: FSM encodings,
// default line/clock rates and the 3-sample majority helper.
// No logic of its own; imported by the receiver top.
package uart_rx_oversample_pkg;

    localparam int DEF_CLK_FREQ  = 100_000_000;
    localparam int DEF_BAUD_RATE = 115200;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_DATA     = 3'd2,
        ST_PARITY   = 3'd3,
        ST_STOP     = 3'd4,
        ST_BRK_WAIT = 3'd5
    } rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Purpose: free-running divider producing a one-clk tick every DIV clocks.
// Latency: first tick DIV clocks after reload; registered output.
// Backpressure: none; reload restarts the period so ticks phase-align to it.
// Ports: clk, rst (async active-low), reload (sync restart), tick (1-clk pulse).
module uart_os_tick #(
    parameter int DIV = 54
) (
    input  logic clk,
    input  logic rst,
    input  logic reload,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (reload) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == LAST) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CW'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_oversample.sv
// Purpose: 8N1/8E1/8O1 UART receiver, 16x oversampled, majority-voted bits.
// Latency: byte visible 1 clk after the stop-bit vote (+2 clk input sync).
// Backpressure: one-entry valid/ready holding reg; a byte completing while full is dropped (overrun_err).
// Ports: clk, rst (async active-low), rx_line in; rx_valid/rx_ready/rx_data out handshake;
//        frame_err/parity_err qualified by rx_valid; overrun_err sticky, cleared by err_clr; busy.
module uart_rx_oversample
    import uart_rx_oversample_pkg::*;
#(
    parameter int CLK_FREQ   = DEF_CLK_FREQ,
    parameter int BAUD_RATE  = DEF_BAUD_RATE,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_line,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun_err,
    input  logic       err_clr,
    output logic       busy
);

    localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int SCW = $clog2(OVERSAMPLE);
    localparam int M   = OVERSAMPLE / 2;
    localparam logic [SCW-1:0] SC_LO   = SCW'(M - 1);
    localparam logic [SCW-1:0] SC_MID  = SCW'(M);
    localparam logic [SCW-1:0] SC_HI   = SCW'(M + 1);
    localparam logic [SCW-1:0] SC_LAST = SCW'(OVERSAMPLE - 1);
    localparam bit PAR_EN  = (PARITY_EN != 0);
    localparam bit PAR_ODD = (PARITY_ODD != 0);

    logic            sync1, rxs;
    rx_state_t       state;
    logic [SCW-1:0]  sc;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            par_bit;
    logic            s_lo, s_mid;
    logic            tick, reload, vote, at_vote, at_wrap, complete, stop_pe;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rx_line;
            rxs   <= sync1;
        end
    end

    // Restarting the divider on the detected falling edge centres the samples in each bit.
    assign reload = (state == ST_IDLE) && !rxs;

    uart_os_tick #(.DIV(DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .reload (reload),
        .tick   (tick)
    );

    // The third sample is the live rxs at the vote tick, so no flop is spent on it.
    assign vote     = maj3(s_lo, s_mid, rxs);
    assign at_vote  = tick && (sc == SC_HI);
    assign at_wrap  = tick && (sc == SC_LAST);
    // Completing at the stop vote rather than at end of bit leaves slack for back-to-back frames.
    assign complete = (state == ST_STOP) && at_vote;
    assign stop_pe  = PAR_EN && ((^shreg ^ par_bit) != PAR_ODD);
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            sc      <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            s_lo    <= 1'b1;
            s_mid   <= 1'b1;
        end else begin
            if (tick) begin
                if (sc == SC_LO)  s_lo  <= rxs;
                if (sc == SC_MID) s_mid <= rxs;
                sc <= (sc == SC_LAST) ? '0 : sc + SCW'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (!rxs) begin
                        sc    <= '0;
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (at_vote && vote) begin
                        state <= ST_IDLE;
                    end else if (at_wrap) begin
                        state   <= ST_DATA;
                        bit_idx <= '0;
                    end
                end
                ST_DATA: begin
                    if (at_vote) shreg <= {vote, shreg[7:1]};
                    if (at_wrap) begin
                        if (bit_idx == 3'd7) state <= PAR_EN ? ST_PARITY : ST_STOP;
                        bit_idx <= bit_idx + 3'd1;
                    end
                end
                ST_PARITY: begin
                    if (at_vote) par_bit <= vote;
                    if (at_wrap) state <= ST_STOP;
                end
                ST_STOP: begin
                    // A low stop bit on an all-zero byte is a break; wait out the low line.
                    if (at_vote) state <= (!vote && shreg == 8'h00) ? ST_BRK_WAIT : ST_IDLE;
                end
                ST_BRK_WAIT: begin
                    if (rxs) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_valid    <= 1'b0;
            rx_data     <= 8'h00;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            // An accept in the completion cycle frees the slot, so the new byte loads.
            if (complete && (!rx_valid || rx_ready)) begin
                rx_valid   <= 1'b1;
                rx_data    <= shreg;
                frame_err  <= !vote;
                parity_err <= stop_pe;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (complete && rx_valid && !rx_ready) overrun_err <= 1'b1;
            else if (err_clr)                      overrun_err <= 1'b0;
        end
    end

endmodule
